// File: rtl/spi_slave.sv
// SPI mode-0 slave: synchronizes the SPI pins into clk_100, shifts MSB-first words in/out,
// supports back-to-back words under one chip select and flags frames cut short by cs_n.
module spi_slave #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_100,
   input  logic              a_rst_n,
   input  logic              sclk_i,
   input  logic              cs_n_i,
   input  logic              mosi_i,
   output logic              miso_o,
   input  logic [DATA_W-1:0] tx_data_i,
   output logic              tx_load_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   output logic              frame_err_o,
   output logic              busy_o
);

   localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_d;
   logic                   cs_d;
   logic                   mosi_d;

   logic                   sclk_rise_p1;
   logic                   sclk_fall_p1;
   logic                   cs_fall_p1;
   logic                   cs_rise_p1;

   state_t                 state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_W-1:0]      tx_sr;
   logic [DATA_W-1:0]      rx_sr;
   logic                   reload_pend;

   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Synchronizer chains plus one delay register per pin for edge detection
   always_ff @(posedge clk_100 or negedge a_rst_n) begin
      if (!a_rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
         mosi_d    <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
         mosi_d    <= mosi_s;
      end
   end

   // Registered edge strobes; mosi_d is captured on the same edge so it lines up with sclk_rise_p1
   always_ff @(posedge clk_100 or negedge a_rst_n) begin
      if (!a_rst_n) begin
         sclk_rise_p1 <= 1'b0;
         sclk_fall_p1 <= 1'b0;
         cs_fall_p1   <= 1'b0;
         cs_rise_p1   <= 1'b0;
      end else begin
         sclk_rise_p1 <= sclk_s & ~sclk_d;
         sclk_fall_p1 <= ~sclk_s & sclk_d;
         cs_fall_p1   <= ~cs_s & cs_d;
         cs_rise_p1   <= cs_s & ~cs_d;
      end
   end

   // Frame control; cs_n edges outrank any SCLK edge seen in the same cycle
   always_ff @(posedge clk_100 or negedge a_rst_n) begin
      if (!a_rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         tx_sr       <= '0;
         rx_sr       <= '0;
         rx_data_o   <= '0;
         reload_pend <= 1'b0;
         miso_o      <= 1'b0;
         tx_load_o   <= 1'b0;
         rx_valid_o  <= 1'b0;
         frame_err_o <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         tx_load_o   <= 1'b0;
         rx_valid_o  <= 1'b0;
         frame_err_o <= 1'b0;

         case (state)
            IDLE: begin
               miso_o <= 1'b0;
               busy_o <= 1'b0;
               if (cs_fall_p1) begin
                  state       <= ACTIVE;
                  busy_o      <= 1'b1;
                  bit_cnt     <= '0;
                  reload_pend <= 1'b0;
                  tx_sr       <= tx_data_i;
                  miso_o      <= tx_data_i[DATA_W-1];
                  tx_load_o   <= 1'b1;
               end
            end

            ACTIVE: begin
               if (cs_rise_p1) begin
                  state       <= IDLE;
                  busy_o      <= 1'b0;
                  miso_o      <= 1'b0;
                  bit_cnt     <= '0;
                  reload_pend <= 1'b0;
                  if (bit_cnt != '0) begin
                     frame_err_o <= 1'b1;
                  end
               end else if (sclk_rise_p1) begin
                  rx_sr <= {rx_sr[DATA_W-2:0], mosi_d};
                  if (bit_cnt == LAST_BIT) begin
                     rx_data_o   <= {rx_sr[DATA_W-2:0], mosi_d};
                     rx_valid_o  <= 1'b1;
                     bit_cnt     <= '0;
                     reload_pend <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end else if (sclk_fall_p1) begin
                  if (bit_cnt != '0) begin
                     tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                     miso_o <= tx_sr[DATA_W-2];
                  end else if (reload_pend) begin
                     // Next word under the same chip select
                     reload_pend <= 1'b0;
                     tx_sr       <= tx_data_i;
                     miso_o      <= tx_data_i[DATA_W-1];
                     tx_load_o   <= 1'b1;
                  end
               end
            end

            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               miso_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, which sets the frame width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, which sets the flip-flop depth of each input synchronizer (legal 2..4).
REQ-003 The block SHALL have port clk_100, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port a_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sclk_i, input, 1 bit: SPI serial clock from the master, asynchronous to clk_100.
REQ-006 The block SHALL have port cs_n_i, input, 1 bit: active-low chip select from the master, asynchronous.
REQ-007 The block SHALL have port mosi_i, input, 1 bit: master-out data, asynchronous.
REQ-008 The block SHALL have port miso_o, output, 1 bit: slave-out data.
REQ-009 The block SHALL have port tx_data_i, input, DATA_W bits: the word to transmit in the next frame.
REQ-010 The block SHALL have port tx_load_o, output, 1 bit: one-cycle pulse when tx_data_i is captured.
REQ-011 The block SHALL have port rx_data_o, output, DATA_W bits: the last complete received word.
REQ-012 The block SHALL have port rx_valid_o, output, 1 bit: one-cycle pulse when rx_data_o is updated.
REQ-013 The block SHALL have port frame_err_o, output, 1 bit: one-cycle pulse when cs_n_i deasserts mid-frame.
REQ-014 The block SHALL have port busy_o, output, 1 bit: high while in state ACTIVE.

Function
REQ-015 sclk_i, cs_n_i and mosi_i SHALL each pass through a SYNC_STAGES-deep synchronizer, followed by one delay register used for edge detection.
REQ-016 The block SHALL support SPI mode 0 only (CPOL=0, CPHA=0), MSB first: MOSI sampled on SCLK rising edges, MISO changed on SCLK falling edges.
REQ-017 SCLK high and low phases SHALL each be at least SYNC_STAGES+2 clk_100 periods; behaviour is undefined for faster SCLK.
REQ-018 The state machine SHALL have two states: IDLE and ACTIVE.
REQ-019 IDLE -> ACTIVE on a synchronized cs_n falling edge; in that cycle the block SHALL load the tx shift register from tx_data_i, pulse tx_load_o, clear bit_cnt, and drive miso_o = tx_data_i[DATA_W-1] from the next cycle.
REQ-020 In ACTIVE, on each synchronized SCLK rising edge the block SHALL shift the synchronized MOSI bit into the rx shift register LSB and increment bit_cnt.
REQ-021 When the rising edge completes bit DATA_W, the block SHALL, on the same clock edge, load rx_data_o with the full word, pulse rx_valid_o, and wrap bit_cnt to 0.
REQ-022 rx_valid_o SHALL rise exactly SYNC_STAGES+1 clk_100 rising edges after the clk_100 edge that first samples the raw completing SCLK rise.
REQ-023 In ACTIVE, on each synchronized SCLK falling edge with bit_cnt != 0, the tx shift register SHALL shift left and miso_o SHALL present the next bit.
REQ-024 On a synchronized SCLK falling edge with bit_cnt == 0 following a completed word (back-to-back frame under one CS), the block SHALL reload from tx_data_i, pulse tx_load_o, and drive its MSB.
REQ-025 ACTIVE -> IDLE on a synchronized cs_n rising edge; if bit_cnt != 0, the block SHALL pulse frame_err_o, discard the partial word, and leave rx_data_o unchanged.
REQ-026 If a cs_n rising edge and an SCLK edge are detected in the same cycle, cs_n SHALL take priority and the SCLK edge SHALL be ignored.
REQ-027 SCLK edges detected in IDLE SHALL be ignored.
REQ-028 miso_o SHALL be 0 in IDLE.
REQ-029 rx_data_o SHALL hold its value until the next completed word.

Reset
REQ-030 While a_rst_n = 0, all synchronizer and edge-detect stages SHALL be set to their idle values (cs_n = 1, sclk = 0, mosi = 0).
REQ-031 While a_rst_n = 0: state = IDLE, bit_cnt = 0, both shift registers = 0, rx_data_o = 0, and miso_o, tx_load_o, rx_valid_o, frame_err_o, busy_o all = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no rx_valid_o or frame_err_o pulse.
REQ-033 After reset release, the block SHALL require a fresh cs_n falling edge before accepting data.

Verification
REQ-034 Single frame: DATA_W=8, tx_data_i=0xA5, master sends 0x3C with SCLK half-period 8 cycles -> one tx_load_o pulse; rx_data_o=0x3C with one rx_valid_o pulse; master receives 0xA5.
REQ-035 Back-to-back frames: master sends 0x01 then 0xFF under one CS, tx_data_i changes 0x11 -> 0x22 between words -> two rx_valid_o pulses (0x01, 0xFF); master receives 0x11 then 0x22.
REQ-036 Aborted frame: cs_n_i rises after 5 bits -> one frame_err_o pulse; no rx_valid_o; rx_data_o keeps its previous value; busy_o = 0.
REQ-037 Latency: measure from the raw 8th SCLK rise to rx_valid_o -> exactly SYNC_STAGES+1 edges, checked for SYNC_STAGES=2 and 3.
REQ-038 Reset mid-frame: a_rst_n pulled low after 3 bits -> all outputs 0 immediately; no pulses; the next full frame 0x5A is received correctly.
REQ-039 SCLK toggling with cs_n_i high -> no rx_valid_o; miso_o stays 0.
